l2_flush_seq: RTL and testbench

L2_FLUSH_SEQ -- requirements
Module: l2_flush_seq

---
 rtl/l2_flush_seq.sv | 135 +++++++++++++
 tb/tb_l2_flush_seq.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_flush_seq.sv
// rtl/l2_flush_seq.sv - L2 set/way walk flush sequencer with writeback and drain
module l2_flush_seq #(
  parameter int L2_SETS        = 256,
  parameter int L2_WAYS        = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int SB             = $clog2(L2_SETS),
  parameter int WB             = $clog2(L2_WAYS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_valid,
  input  logic                      flush_all,
  output logic                      flush_ready,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [SB-1:0]             rd_set,
  output logic [WB-1:0]             rd_way,
  input  logic [WORDS_PER_LINE-1:0] rd_word_valid,
  input  logic                      rd_hprot,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [SB-1:0]             wb_set,
  output logic [WB-1:0]             wb_way,
  input  logic                      drain_empty,
  output logic                      busy,
  output logic                      flush_done,
  output logic                      acc_flush_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CHK,
    S_WBK,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [SB-1:0] LAST_SET = SB'(L2_SETS - 1);
  localparam logic [WB-1:0] LAST_WAY = WB'(L2_WAYS - 1);

  state_t        state_q, state_d;
  logic [SB-1:0] set_q, set_d;
  logic [WB-1:0] way_q, way_d;
  logic          mode_q, mode_d;
  logic          advance;
  logic          candidate;

  // A line needs eviction if any word is valid and the flush mode covers it
  assign candidate = (|rd_word_valid) & (mode_q | ~rd_hprot);

  // Both request channels always present the walk position; valid qualifies them
  assign rd_set = set_q;
  assign rd_way = way_q;
  assign wb_set = set_q;
  assign wb_way = way_q;
  assign busy   = (state_q != S_IDLE);

  // State, walk counters and latched flush mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      set_q   <= '0;
      way_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      way_q   <= way_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state, counter advance and handshake outputs
  always_comb begin
    state_d        = state_q;
    set_d          = set_q;
    way_d          = way_q;
    mode_d         = mode_q;
    advance        = 1'b0;
    flush_ready    = 1'b0;
    rd_valid       = 1'b0;
    wb_valid       = 1'b0;
    flush_done     = 1'b0;
    acc_flush_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        flush_ready = 1'b1;
        if (flush_valid) begin
          mode_d  = flush_all;
          set_d   = '0;
          way_d   = '0;
          state_d = S_RD;
        end
      end
      S_RD: begin
        rd_valid = 1'b1;
        if (rd_ready) state_d = S_CHK;
      end
      S_CHK: begin
        if (candidate) state_d = S_WBK;
        else           advance = 1'b1;
      end
      S_WBK: begin
        wb_valid = 1'b1;
        if (wb_ready) advance = 1'b1;
      end
      S_DRAIN: begin
        if (drain_empty) state_d = S_DONE;
      end
      S_DONE: begin
        flush_done     = mode_q;
        acc_flush_done = ~mode_q;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // End of walk is found by comparing against the last index, so counters never wrap
    if (advance) begin
      if (way_q != LAST_WAY) begin
        way_d   = way_q + 1'b1;
        state_d = S_RD;
      end else if (set_q != LAST_SET) begin
        way_d   = '0;
        set_d   = set_q + 1'b1;
        state_d = S_RD;
      end else begin
        state_d = S_DRAIN;
      end
    end
  end

endmodule

// File: tb/tb_l2_flush_seq.sv
// tb/tb_l2_flush_seq.sv - scoreboard bench for l2_flush_seq with a set/way walk model
module tb_l2_flush_seq;
  localparam int L2_SETS = 4;
  localparam int L2_WAYS = 2;
  localparam int WPL     = 4;
  localparam int SB      = 2;
  localparam int WB      = 1;
  localparam int N       = L2_SETS * L2_WAYS;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush_valid = 1'b0;
  logic           flush_all = 1'b0;
  logic           flush_ready;
  logic           rd_valid;
  logic           rd_ready = 1'b1;
  logic [SB-1:0]  rd_set;
  logic [WB-1:0]  rd_way;
  logic [WPL-1:0] rd_word_valid = '0;
  logic           rd_hprot = 1'b0;
  logic           wb_valid;
  logic           wb_ready = 1'b1;
  logic [SB-1:0]  wb_set;
  logic [WB-1:0]  wb_way;
  logic           drain_empty = 1'b1;
  logic           busy;
  logic           flush_done;
  logic           acc_flush_done;

  l2_flush_seq #(.L2_SETS(L2_SETS), .L2_WAYS(L2_WAYS), .WORDS_PER_LINE(WPL)) dut (
    .clk(clk), .rst(rst), .flush_valid(flush_valid), .flush_all(flush_all),
    .flush_ready(flush_ready), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_set(rd_set), .rd_way(rd_way), .rd_word_valid(rd_word_valid),
    .rd_hprot(rd_hprot), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_set(wb_set), .wb_way(wb_way), .drain_empty(drain_empty), .busy(busy),
    .flush_done(flush_done), .acc_flush_done(acc_flush_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 read, 1 writeback, 2 flush_done, 3 acc_flush_done
  typedef struct {
    int kind;
    int s;
    int w;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;
  logic [WPL-1:0] mem_wv [N];
  logic           mem_hp [N];
  bit   rand_mode = 1'b0;
  logic rd_force = 1'b1;
  logic wb_force = 1'b1;
  logic drain_force = 1'b1;
  int t0 = 0;
  int done_cyc = -1;
  int first_rd_cyc = -1;
  int n_fd = 0;
  int n_acc = 0;
  int n_wb = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event_missing_or_unexpected expected=ok (cycle %0d)", name, cyc);
  endtask

  // Reference walk: every entry read in set-major order, evict if any word valid and mode covers it
  function automatic void build_expected(bit mode);
    exp_t e;
    for (int s = 0; s < L2_SETS; s++) begin
      for (int w = 0; w < L2_WAYS; w++) begin
        e.kind = 0; e.s = s; e.w = w;
        q.push_back(e);
        if (mem_wv[s*L2_WAYS+w] != '0 && (mode || !mem_hp[s*L2_WAYS+w])) begin
          e.kind = 1;
          q.push_back(e);
        end
      end
    end
    e.kind = mode ? 2 : 3; e.s = 0; e.w = 0;
    q.push_back(e);
  endfunction

  // Ready/drain drivers, applied late in the cycle so stimulus updates settle first
  initial forever begin
    @(posedge clk);
    #2;
    if (rand_mode) begin
      rd_ready    = ($urandom_range(0, 3) != 0);
      wb_ready    = ($urandom_range(0, 2) != 0);
      drain_empty = ($urandom_range(0, 3) == 0);
    end else begin
      rd_ready    = rd_force;
      wb_ready    = wb_force;
      drain_empty = drain_force;
    end
  end

  // Line-state responder: data one cycle after the read handshake, noise otherwise
  initial begin
    bit hs;
    int idx;
    forever begin
      @(negedge clk);
      hs  = rd_valid && rd_ready;
      idx = int'(rd_set) * L2_WAYS + int'(rd_way);
      @(posedge clk);
      #1;
      if (hs) begin
        rd_word_valid = mem_wv[idx];
        rd_hprot      = mem_hp[idx];
      end else begin
        rd_word_valid = 4'($urandom);
        rd_hprot      = 1'($urandom);
      end
    end
  end

  // Monitor: compare every presented request and completion pulse against the queue front
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("rd_wb_exclusive", int'(rd_valid && wb_valid), 0);
      chk("busy_vs_ready", int'(busy), int'(!flush_ready));
      if (rd_valid) begin
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        if (q.size() == 0) fail_evt("unexpected_rd");
        else begin
          chk("rd_kind", 0, q[0].kind);
          chk("rd_set", int'(rd_set), q[0].s);
          chk("rd_way", int'(rd_way), q[0].w);
          if (rd_ready && q[0].kind == 0) void'(q.pop_front());
        end
      end
      if (wb_valid) begin
        if (q.size() == 0) fail_evt("unexpected_wb");
        else begin
          chk("wb_kind", 1, q[0].kind);
          chk("wb_set", int'(wb_set), q[0].s);
          chk("wb_way", int'(wb_way), q[0].w);
          if (wb_ready && q[0].kind == 1) begin
            void'(q.pop_front());
            n_wb++;
          end
        end
      end
      if (flush_done || acc_flush_done) begin
        chk("done_both", int'(flush_done && acc_flush_done), 0);
        done_cyc = cyc;
        if (flush_done) n_fd++; else n_acc++;
        if (q.size() == 0) fail_evt("unexpected_done");
        else begin
          chk("done_kind", flush_done ? 2 : 3, q[0].kind);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < N; i++) begin
      mem_wv[i] = '0;
      mem_hp[i] = 1'b0;
    end
  endtask

  task automatic start_flush(bit mode);
    int n;
    n = 0;
    @(negedge clk);
    while (!flush_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!flush_ready) fail_evt("idle_timeout");
    @(posedge clk);
    #1;
    flush_valid  = 1'b1;
    flush_all    = mode;
    t0           = cyc;
    first_rd_cyc = -1;
    build_expected(mode);
    @(posedge clk);
    #1;
    flush_valid = 1'b0;
    flush_all   = 1'($urandom);
  endtask

  task automatic wait_done(int limit);
    int n;
    n = 0;
    @(negedge clk);
    while (!(flush_ready && q.size() == 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!(flush_ready && q.size() == 0)) begin
      fail_evt("walk_timeout");
      q.delete();
    end
  endtask

  task automatic wait_until_cyc(int c);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    while (cyc < c && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_rd_valid"}, int'(rd_valid), 0);
    chk({tag, "_wb_valid"}, int'(wb_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_flush_ready"}, int'(flush_ready), 1);
    chk({tag, "_flush_done"}, int'(flush_done), 0);
    chk({tag, "_acc_done"}, int'(acc_flush_done), 0);
    chk({tag, "_rd_set"}, int'(rd_set), 0);
    chk({tag, "_rd_way"}, int'(rd_way), 0);
    chk({tag, "_wb_set"}, int'(wb_set), 0);
    chk({tag, "_wb_way"}, int'(wb_way), 0);
  endtask

  initial begin
    int base_fd, base_acc, base_wb, n;
    clear_mem();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Empty cache full flush: 8 reads in order, done pulse 18 cycles after accept
    base_wb = n_wb;
    start_flush(1'b1);
    wait_done(200);
    chk("t31_first_rd_cycle", first_rd_cyc - t0, 1);
    chk("t31_done_cycle", done_cyc - t0, 18);
    chk("t31_no_wb", n_wb - base_wb, 0);

    // Accelerator flush evicts only the hprot=0 line
    clear_mem();
    mem_wv[2*L2_WAYS+1] = 4'b0010; mem_hp[2*L2_WAYS+1] = 1'b0;
    mem_wv[1*L2_WAYS+0] = 4'b1111; mem_hp[1*L2_WAYS+0] = 1'b1;
    base_fd = n_fd; base_acc = n_acc; base_wb = n_wb;
    start_flush(1'b0);
    wait_done(200);
    chk("t32_wb_count", n_wb - base_wb, 1);
    chk("t32_acc_pulses", n_acc - base_acc, 1);
    chk("t32_fd_pulses", n_fd - base_fd, 0);

    // Writeback back-pressure: request held stable for 6 cycles, no reads meanwhile
    clear_mem();
    mem_wv[1] = 4'b0001; mem_hp[1] = 1'($urandom);
    wb_force = 1'b0;
    start_flush(1'b1);
    n = 0;
    @(negedge clk);
    while (!wb_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!wb_valid) fail_evt("t33_wb_timeout");
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
        if (i == 5) wb_force = 1'b1;
        @(negedge clk);
      end
      chk("t33_wb_valid", int'(wb_valid), 1);
      chk("t33_wb_set", int'(wb_set), 0);
      chk("t33_wb_way", int'(wb_way), 1);
      chk("t33_no_rd", int'(rd_valid), 0);
    end
    wb_force = 1'b1;
    wait_done(200);

    // Drain held off for 10 cycles delays the done pulse by exactly 10
    clear_mem();
    drain_force = 1'b0;
    start_flush(1'b1);
    wait_until_cyc(t0 + 22);
    @(negedge clk);
    chk("t34_busy_in_drain", int'(busy), 1);
    chk("t34_no_req_in_drain", int'(rd_valid || wb_valid), 0);
    wait_until_cyc(t0 + 27);
    drain_force = 1'b1;
    wait_done(200);
    chk("t34_done_cycle", done_cyc - t0, 28);

    // Reset mid-walk aborts at once with no pulse; next flush restarts at (0,0)
    clear_mem();
    start_flush(1'b1);
    n = 0;
    @(negedge clk);
    while (!(rd_valid && rd_set == 2) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(rd_valid && rd_set == 2)) fail_evt("t35_set2_timeout");
    base_fd = n_fd; base_acc = n_acc;
    #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("t35");
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("t35_no_pulse", (n_fd - base_fd) + (n_acc - base_acc), 0);
    mem_wv[0] = 4'b1000;
    start_flush(1'b1);
    wait_done(200);
    chk("t35_restart_first_rd", first_rd_cyc - t0, 1);

    // Flush request while busy is ignored, including the flush_all value it carries
    clear_mem();
    for (int i = 0; i < N; i++) begin
      mem_wv[i] = 4'($urandom);
      mem_hp[i] = 1'($urandom);
    end
    base_fd = n_fd; base_acc = n_acc;
    start_flush(1'b1);
    wait_until_cyc(t0 + 5);
    flush_valid = 1'b1;
    flush_all   = 1'b0;
    @(posedge clk);
    #1;
    flush_valid = 1'b0;
    wait_done(300);
    repeat (20) @(negedge clk);
    chk("t36_idle_after", int'(busy), 0);
    chk("t36_fd_pulses", n_fd - base_fd, 1);
    chk("t36_acc_pulses", n_acc - base_acc, 0);

    // Randomized walks with random contents, mode and back-pressure
    rand_mode = 1'b1;
    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < N; i++) begin
        mem_wv[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
        mem_hp[i] = 1'($urandom);
      end
      start_flush(1'($urandom));
      wait_done(3000);
    end
    rand_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("final_queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
